// File: rtl/fsm_initiator.sv
// Initiator side of the START / SIG_1 / SIG_2 two-phase sequencer handshake.
// Raises START on request, tracks both responder phases and reports DONE or ERR with a code.
module fsm_initiator #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ,
    input  logic             SIG_1,
    input  logic             SIG_2,
    output logic             START,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic [1:0]       ERR_CODE,
    output logic [CNT_W-1:0] TX_CNT,
    output logic [CNT_W-1:0] ERR_CNT
);

    localparam int unsigned      TMR_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    localparam logic [1:0] CodeNoResp = 2'd1;
    localparam logic [1:0] CodeStall  = 2'd2;
    localparam logic [1:0] CodeOrder  = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StReqStart,
        StWait2,
        StWaitLow,
        StError
    } state_e;

    state_e           state;
    logic [TMR_W-1:0] timer;
    logic             timed_out;
    logic             fail;
    logic [1:0]       fail_code;

    assign timed_out = (timer == TMR_LAST);

    // Abort decode: protocol violations outrank the timeout, and a met exit condition
    // never produces a fail, so the exit wins over a coincident timeout.
    always_comb begin
        fail      = 1'b0;
        fail_code = 2'd0;
        case (state)
            StReqStart: begin
                if (SIG_2) begin
                    fail      = 1'b1;
                    fail_code = CodeOrder;
                end else if (!SIG_1 && timed_out) begin
                    fail      = 1'b1;
                    fail_code = CodeNoResp;
                end
            end
            StWait2: begin
                if (!SIG_1) begin
                    fail      = 1'b1;
                    fail_code = CodeOrder;
                end else if (!SIG_2 && timed_out) begin
                    fail      = 1'b1;
                    fail_code = CodeStall;
                end
            end
            StWaitLow: begin
                if (SIG_1 != SIG_2) begin
                    fail      = 1'b1;
                    fail_code = CodeOrder;
                end else if (SIG_1 && timed_out) begin
                    fail      = 1'b1;
                    fail_code = CodeStall;
                end
            end
            default: begin
                fail      = 1'b0;
                fail_code = 2'd0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= StIdle;
            timer    <= '0;
            START    <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            ERR_CODE <= 2'd0;
            TX_CNT   <= '0;
            ERR_CNT  <= '0;
        end else begin
            DONE <= 1'b0;
            ERR  <= 1'b0;
            if (fail) begin
                state    <= StError;
                timer    <= '0;
                START    <= 1'b0;
                ERR      <= 1'b1;
                ERR_CODE <= fail_code;
                ERR_CNT  <= ERR_CNT + 1'b1;
            end else begin
                case (state)
                    StIdle: begin
                        // A request is held off while the responder still shows activity.
                        if (REQ && !SIG_1 && !SIG_2) begin
                            state <= StReqStart;
                            timer <= '0;
                            START <= 1'b1;
                            BUSY  <= 1'b1;
                        end
                    end
                    StReqStart: begin
                        if (SIG_1 && !SIG_2) begin
                            state <= StWait2;
                            timer <= '0;
                            START <= 1'b0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    StWait2: begin
                        if (SIG_1 && SIG_2) begin
                            state <= StWaitLow;
                            timer <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    StWaitLow: begin
                        if (!SIG_1 && !SIG_2) begin
                            state  <= StIdle;
                            timer  <= '0;
                            BUSY   <= 1'b0;
                            DONE   <= 1'b1;
                            TX_CNT <= TX_CNT + 1'b1;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    StError: begin
                        state <= StIdle;
                        timer <= '0;
                        BUSY  <= 1'b0;
                    end
                    default: begin
                        state <= StIdle;
                        timer <= '0;
                        START <= 1'b0;
                        BUSY  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fsm_initiator.sv
// Bench for fsm_initiator: directed vector table, hand-written corner sequences and a
// randomized run, all checked against a phase-pattern reference model.
module tb_fsm_initiator;

    localparam int TO = 16;

    logic       clk;
    logic       rst;
    logic       req;
    logic       sig_1;
    logic       sig_2;
    logic       start, busy, done, err;
    logic [1:0] err_code;
    logic [7:0] tx_cnt, err_cnt;
    logic       start_w, busy_w, done_w, err_w;
    logic [1:0] err_code_w;
    logic [1:0] tx_cnt_w, err_cnt_w;

    fsm_initiator #(.TIMEOUT(TO), .CNT_W(8)) u_dut (
        .CLK(clk), .RST(rst), .REQ(req), .SIG_1(sig_1), .SIG_2(sig_2),
        .START(start), .BUSY(busy), .DONE(done), .ERR(err), .ERR_CODE(err_code),
        .TX_CNT(tx_cnt), .ERR_CNT(err_cnt)
    );

    fsm_initiator #(.TIMEOUT(TO), .CNT_W(2)) u_dut_w (
        .CLK(clk), .RST(rst), .REQ(req), .SIG_1(sig_1), .SIG_2(sig_2),
        .START(start_w), .BUSY(busy_w), .DONE(done_w), .ERR(err_w), .ERR_CODE(err_code_w),
        .TX_CNT(tx_cnt_w), .ERR_CNT(err_cnt_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model. A handshake is phase 1..3; each phase has one input pattern
    // {SIG_1,SIG_2} that holds it and one that advances it; anything else is an order
    // error. Phase 4 is the one-cycle error report.
    bit [1:0] hold_pat [4] = '{2'b00, 2'b00, 2'b10, 2'b11};
    bit [1:0] adv_pat  [4] = '{2'b00, 2'b10, 2'b11, 2'b00};
    int       ph, dwell, m_tx, m_errs;
    bit       m_start, m_busy, m_done, m_err;
    bit [1:0] m_code;

    task automatic m_abort(input bit [1:0] c);
        ph      = 4;
        m_start = 0;
        m_err   = 1;
        m_code  = c;
        m_errs++;
    endtask

    task automatic model_step(input bit r, input bit q, input bit s1, input bit s2);
        bit [1:0] pat;
        pat    = {s1, s2};
        m_done = 0;
        m_err  = 0;
        if (r) begin
            ph = 0; dwell = 0; m_tx = 0; m_errs = 0;
            m_start = 0; m_busy = 0; m_code = 0;
        end else if (ph == 4) begin
            ph     = 0;
            m_busy = 0;
        end else if (ph == 0) begin
            if (q && pat == 2'b00) begin
                ph = 1; dwell = 0; m_start = 1; m_busy = 1;
            end
        end else begin
            dwell++;
            if (pat == adv_pat[ph]) begin
                dwell = 0;
                if (ph == 3) begin
                    ph = 0; m_done = 1; m_busy = 0; m_tx++;
                end else begin
                    ph++;
                    m_start = 0;
                end
            end else if (pat != hold_pat[ph]) begin
                m_abort(2'd3);
            end else if (dwell == TO) begin
                m_abort(ph == 1 ? 2'd1 : 2'd2);
            end
        end
    endtask

    task automatic model_check();
        chk("start", start, m_start);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("err", err, m_err);
        chk("err_code", err_code, m_code);
        chk("tx_cnt", tx_cnt, m_tx % 256);
        chk("err_cnt", err_cnt, m_errs % 256);
        chk("start_w", start_w, m_start);
        chk("tx_cnt_w", tx_cnt_w, m_tx % 4);
        chk("err_cnt_w", err_cnt_w, m_errs % 4);
    endtask

    // One clock: inputs applied at the falling edge, outputs checked at the next one.
    task automatic drive(input bit r, input bit q, input bit a, input bit b);
        rst   = r;
        req   = q;
        sig_1 = a;
        sig_2 = b;
        @(posedge clk);
        model_step(r, q, a, b);
        @(negedge clk);
        model_check();
    endtask

    // Behavioural responder: sees START, waits, raises SIG_1, then SIG_2, then drops both.
    int rs = 0, dly = 0, hold_n = 0;
    bit early = 0, drop = 0, force_s1 = 0, rand_on = 0;
    int p_dly = 0, p_hold = 0;
    bit p_early = 0, p_drop = 0;

    task automatic respond(output bit a, output bit b);
        a = 0;
        b = 0;
        case (rs)
            0: if (start) begin
                rs = 1;
                if (rand_on) begin
                    dly    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 18) : 0;
                    early  = ($urandom_range(0, 9) == 0);
                    drop   = ($urandom_range(0, 9) == 0);
                    hold_n = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 20) : 0;
                end else begin
                    dly = p_dly; early = p_early; drop = p_drop; hold_n = p_hold;
                end
            end
            1: if (dly > 0) dly--; else rs = 2;
            2: begin a = !early; b = early; rs = 3; end
            3: begin a = !drop; b = !drop; rs = 4; end
            4: if (!drop && hold_n > 0) begin
                a = 1; b = 1; hold_n--;
            end else begin
                rs = 0;
            end
            default: rs = 0;
        endcase
        if (force_s1) a = 1;
    endtask

    task automatic tick(input bit r, input bit q);
        bit a, b;
        respond(a, b);
        if (rand_on && $urandom_range(0, 24) == 0) begin
            if ($urandom_range(0, 1) == 1) a = !a;
            else b = !b;
        end
        if (r) rs = 0;
        drive(r, q, a, b);
    endtask

    task automatic do_reset();
        tick(1, 0);
        tick(1, 0);
    endtask

    typedef struct {
        bit       rst, req, s1, s2;
        bit       start, busy, done, err;
        bit [1:0] code;
        int       tx, ec;
    } vec_t;

    vec_t tbl[21];
    int   wrap_exp[5] = '{1, 2, 3, 0, 1};

    initial begin
        int start_hi, done_at, err_at, n_done, last, gap_bad, bad, got;
        rst = 1; req = 0; sig_1 = 0; sig_2 = 0;

        //          rst req s1 s2  start busy done err code tx ec
        tbl[0]  = '{1, 0, 0, 0,    0, 0, 0, 0, 2'd0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0,    0, 0, 0, 0, 2'd0, 0, 0};
        tbl[2]  = '{0, 1, 0, 0,    1, 1, 0, 0, 2'd0, 0, 0};
        tbl[3]  = '{0, 0, 0, 0,    1, 1, 0, 0, 2'd0, 0, 0};
        tbl[4]  = '{0, 0, 0, 0,    1, 1, 0, 0, 2'd0, 0, 0};
        tbl[5]  = '{0, 0, 1, 0,    0, 1, 0, 0, 2'd0, 0, 0};
        tbl[6]  = '{0, 0, 1, 1,    0, 1, 0, 0, 2'd0, 0, 0};
        tbl[7]  = '{0, 0, 0, 0,    0, 0, 1, 0, 2'd0, 1, 0};
        tbl[8]  = '{0, 1, 1, 0,    0, 0, 0, 0, 2'd0, 1, 0};
        tbl[9]  = '{0, 1, 0, 0,    1, 1, 0, 0, 2'd0, 1, 0};
        tbl[10] = '{0, 0, 0, 1,    0, 1, 0, 1, 2'd3, 1, 1};
        tbl[11] = '{0, 1, 0, 0,    0, 0, 0, 0, 2'd3, 1, 1};
        tbl[12] = '{0, 1, 0, 0,    1, 1, 0, 0, 2'd3, 1, 1};
        tbl[13] = '{0, 0, 1, 0,    0, 1, 0, 0, 2'd3, 1, 1};
        tbl[14] = '{0, 0, 0, 1,    0, 1, 0, 1, 2'd3, 1, 2};
        tbl[15] = '{0, 0, 0, 0,    0, 0, 0, 0, 2'd3, 1, 2};
        tbl[16] = '{0, 1, 0, 0,    1, 1, 0, 0, 2'd3, 1, 2};
        tbl[17] = '{0, 0, 1, 0,    0, 1, 0, 0, 2'd3, 1, 2};
        tbl[18] = '{1, 0, 1, 1,    0, 0, 0, 0, 2'd0, 0, 0};
        tbl[19] = '{0, 0, 0, 0,    0, 0, 0, 0, 2'd0, 0, 0};
        tbl[20] = '{0, 1, 0, 0,    1, 1, 0, 0, 2'd0, 0, 0};

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].rst, tbl[i].req, tbl[i].s1, tbl[i].s2);
            chk($sformatf("tbl[%0d].start", i), start, tbl[i].start);
            chk($sformatf("tbl[%0d].busy", i), busy, tbl[i].busy);
            chk($sformatf("tbl[%0d].done", i), done, tbl[i].done);
            chk($sformatf("tbl[%0d].err", i), err, tbl[i].err);
            chk($sformatf("tbl[%0d].code", i), err_code, tbl[i].code);
            chk($sformatf("tbl[%0d].tx", i), tx_cnt, tbl[i].tx);
            chk($sformatf("tbl[%0d].ec", i), err_cnt, tbl[i].ec);
        end

        // Nominal single handshake.
        do_reset();
        start_hi = 0; done_at = -1; bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick(0, i == 0);
            if (start) start_hi++;
            if (done && done_at < 0) done_at = i;
            if (err) bad++;
        end
        chk("nom_start_cycles", start_hi, 3);
        chk("nom_done_edge", done_at, 5);
        chk("nom_tx", tx_cnt, 1);
        chk("nom_err_pulses", bad, 0);

        // REQ held high: back-to-back handshakes every 6 cycles.
        do_reset();
        n_done = 0; last = -1; gap_bad = 0;
        for (int i = 0; i < 24; i++) begin
            tick(0, i < 18);
            if (done) begin
                if (last >= 0 && i - last != 6) gap_bad++;
                last = i;
                n_done++;
            end
        end
        chk("b2b_done_count", n_done, 3);
        chk("b2b_period", gap_bad, 0);
        chk("b2b_tx", tx_cnt, 3);
        chk("b2b_err_cnt", err_cnt, 0);

        // No response at all.
        do_reset();
        p_dly = 1000; start_hi = 0; err_at = -1;
        for (int i = 0; i < 24; i++) begin
            tick(0, i == 0);
            if (start) start_hi++;
            if (err && err_at < 0) err_at = i;
        end
        chk("noresp_start_cycles", start_hi, 16);
        chk("noresp_err_edge", err_at, 16);
        chk("noresp_code", err_code, 1);
        chk("noresp_err_cnt", err_cnt, 1);
        chk("noresp_busy", busy, 0);
        chk("noresp_start", start, 0);
        p_dly = 0;

        // SIG_2 while START is still pending.
        do_reset();
        p_early = 1; err_at = -1;
        for (int i = 0; i < 8; i++) begin
            tick(0, i == 0);
            if (err && err_at < 0) err_at = i;
        end
        chk("early_err_edge", err_at, 3);
        chk("early_code", err_code, 3);
        p_early = 0;

        // SIG_1 dropped before SIG_2.
        do_reset();
        p_drop = 1; err_at = -1;
        for (int i = 0; i < 8; i++) begin
            tick(0, i == 0);
            if (err && err_at < 0) err_at = i;
        end
        chk("drop_err_edge", err_at, 4);
        chk("drop_code", err_code, 3);
        p_drop = 0;

        // Both signals stuck high after the sequence.
        do_reset();
        p_hold = 40; err_at = -1;
        for (int i = 0; i < 50; i++) begin
            tick(0, i == 0);
            if (err && err_at < 0) err_at = i;
        end
        chk("stuck_err_edge", err_at, 20);
        chk("stuck_code", err_code, 2);
        chk("stuck_err_cnt", err_cnt, 1);
        p_hold = 0;

        // Reset while waiting for SIG_2, then a clean handshake.
        do_reset();
        for (int i = 0; i < 6; i++) tick(0, i == 0);
        chk("rstmid_tx_before", tx_cnt, 1);
        for (int i = 0; i < 4; i++) tick(0, i == 0);
        tick(1, 0);
        chk("rstmid_start", start, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_tx", tx_cnt, 0);
        chk("rstmid_err_cnt", err_cnt, 0);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick(0, 0);
            if (done || err) bad++;
        end
        chk("rstmid_no_pulse", bad, 0);
        for (int i = 0; i < 6; i++) tick(0, i == 0);
        chk("rstmid_tx_after", tx_cnt, 1);

        // 2-bit counter wrap on the narrow instance.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            got = -1;
            for (int j = 0; j < 6; j++) begin
                tick(0, j == 0);
                if (done_w) got = tx_cnt_w;
            end
            chk($sformatf("wrap[%0d]", k), got, wrap_exp[k]);
        end

        // REQ held off while SIG_1 is stuck high in IDLE.
        force_s1 = 1; bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick(0, 1);
            if (start || busy || err) bad++;
        end
        chk("holdoff_quiet", bad, 0);
        force_s1 = 0;
        tick(0, 1);
        chk("holdoff_release_start", start, 1);
        for (int i = 0; i < 8; i++) tick(0, 0);

        // Randomized run against the model.
        do_reset();
        rand_on = 1;
        for (int i = 0; i < 2000; i++) tick($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1);
        rand_on = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
